// File: rtl/evr_pkg.sv
// Shared constants and event decoding for the event-receiver timestamp blocks.
package evr_pkg;

  // Default event codes carried on the 8-bit event stream
  localparam logic [7:0] EVT_CODE_NONE  = 8'h00;
  localparam logic [7:0] EVT_CODE_ZERO  = 8'h70;
  localparam logic [7:0] EVT_CODE_ONE   = 8'h71;
  localparam logic [7:0] EVT_CODE_LATCH = 8'h7D;

  // Width of the saturating bad-latch counter
  localparam int ERRCNT_WIDTH = 16;

  // Classified meaning of one event-stream cycle
  typedef enum logic [1:0] {
    EvNone,
    EvZero,
    EvOne,
    EvLatch
  } evtKind_e;

  // Map a raw event code onto its meaning; the codes are passed in so that
  // per-instance parameter overrides are honoured.
  function automatic evtKind_e decodeEvent(input logic [7:0] code,
                                           input logic [7:0] zeroCode,
                                           input logic [7:0] oneCode,
                                           input logic [7:0] latchCode);
    evtKind_e kind;
    kind = EvNone;
    if (code == zeroCode) begin
      kind = EvZero;
    end else if (code == oneCode) begin
      kind = EvOne;
    end else if (code == latchCode) begin
      kind = EvLatch;
    end
    return kind;
  endfunction

endpackage

// File: rtl/evr_delay_line.sv
// Fixed-latency register pipeline; DEPTH=0 degenerates to a wire.
module evr_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : gWire
      // Clock and Reset are intentionally unused when there is no pipeline
      logic unusedInputs;
      assign unusedInputs = Clock ^ Reset;
      assign dout = din;
    end else begin : gPipe
      logic [WIDTH-1:0] stages [DEPTH];

      // Shift the input through DEPTH stages, clearing every stage on reset
      always_ff @(posedge Clock) begin
        // NOTE: registers are written with <= so every stage samples the
        // value its neighbour held before this edge, not the new one.
        if (Reset) begin
          // NOTE: each stage is reset explicitly because a stale timestamp
          // must never leak out after Reset; storage that is not observable
          // before being rewritten would normally be left unreset.
          for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= '0;
          end
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/evr_tod_receiver.sv
// Time-of-day receiver: assembles a serial seconds word from data events,
// loads it into a free-running {seconds, ticks} register on a latch event,
// and presents the time through a fixed-latency output pipeline.
module evr_tod_receiver
  import evr_pkg::*;
#(
  parameter int         SEC_WIDTH      = 32,
  parameter int         FRAC_WIDTH     = 32,
  parameter int         FRAC_MAX       = 0,
  parameter int         DLY_DEPTH      = 2,
  parameter int         TIMEOUT_CYCLES = 0,
  parameter logic [7:0] EVT_ZERO       = EVT_CODE_ZERO,
  parameter logic [7:0] EVT_ONE        = EVT_CODE_ONE,
  parameter logic [7:0] EVT_LATCH      = EVT_CODE_LATCH
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [7:0]                    EventStream,
  output logic [SEC_WIDTH+FRAC_WIDTH-1:0] TimeStamp,
  output logic                          TimeValid,
  output logic                          LatchStrobe,
  output logic [ERRCNT_WIDTH-1:0]       ErrorCount,
  output logic [5:0]                    BitCount
);

  localparam int TW = SEC_WIDTH + FRAC_WIDTH;

  // Bit count meaning "exactly one full seconds word received"
  localparam logic [5:0] BIT_FULL = 6'(SEC_WIDTH);
  // Saturation value of the bit count; flags an over-long burst
  localparam logic [5:0] BIT_SAT  = 6'(SEC_WIDTH + 1);
  // Last tick value before the seconds field advances
  localparam logic [FRAC_WIDTH-1:0] FRAC_LAST =
    FRAC_WIDTH'(FRAC_MAX == 0 ? 0 : FRAC_MAX - 1);
  // Timeout counter value at which valid is dropped on the next edge
  localparam logic [31:0] TO_LAST =
    32'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

  evtKind_e              evtKind;
  logic                  isData;
  logic                  isLatch;
  logic                  goodLatch;
  logic                  badLatch;

  logic [SEC_WIDTH-1:0]  shiftReg;
  logic [5:0]            bitCnt;
  logic [TW-1:0]         timeReg;
  logic [TW-1:0]         timeNext;
  logic                  validReg;
  logic                  strobeReg;
  logic [31:0]           toCnt;
  logic [ERRCNT_WIDTH-1:0] errCnt;

  logic [SEC_WIDTH-1:0]  seconds;
  logic [FRAC_WIDTH-1:0] ticks;
  logic [TW+1:0]         dlyOut;

  assign seconds = timeReg[TW-1:FRAC_WIDTH];
  assign ticks   = timeReg[FRAC_WIDTH-1:0];

  // Classify the current event and judge whether a latch is good
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first, so
    // no storage is implied for a combinational block.
    evtKind   = decodeEvent(EventStream, EVT_ZERO, EVT_ONE, EVT_LATCH);
    isData    = (evtKind == EvZero) || (evtKind == EvOne);
    isLatch   = (evtKind == EvLatch);
    goodLatch = isLatch && (bitCnt == BIT_FULL);
    badLatch  = isLatch && (bitCnt != BIT_FULL);
  end

  // Next time value: a good latch wins over tick rollover and plain increment
  always_comb begin
    timeNext = timeReg + TW'(1);
    if (FRAC_MAX != 0) begin
      if (ticks == FRAC_LAST) begin
        timeNext = {seconds + SEC_WIDTH'(1), {FRAC_WIDTH{1'b0}}};
      end else begin
        timeNext = {seconds, ticks + FRAC_WIDTH'(1)};
      end
    end
    if (goodLatch) begin
      timeNext = {shiftReg, {FRAC_WIDTH{1'b0}}};
    end
  end

  // Serial seconds assembly; a latch of either kind restarts the word
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shiftReg <= '0;
      bitCnt   <= '0;
    end else if (isLatch) begin
      shiftReg <= '0;
      bitCnt   <= '0;
    end else if (isData) begin
      // Shifting left keeps the first received bit heading for the MSB
      shiftReg <= (shiftReg << 1) | SEC_WIDTH'(evtKind == EvOne);
      if (bitCnt != BIT_SAT) begin
        bitCnt <= bitCnt + 6'd1;
      end
    end
  end

  // Free-running time register and the load strobe aligned with it
  always_ff @(posedge Clock) begin
    if (Reset) begin
      timeReg   <= '0;
      strobeReg <= 1'b0;
    end else begin
      timeReg   <= timeNext;
      strobeReg <= goodLatch;
    end
  end

  // Validity tracking: set by a good latch, dropped by a bad one or a timeout
  always_ff @(posedge Clock) begin
    if (Reset) begin
      validReg <= 1'b0;
      toCnt    <= '0;
    end else if (goodLatch) begin
      validReg <= 1'b1;
      toCnt    <= '0;
    end else if (badLatch) begin
      validReg <= 1'b0;
    end else if (validReg) begin
      if ((TIMEOUT_CYCLES != 0) && (toCnt == TO_LAST)) begin
        validReg <= 1'b0;
      end
      if (toCnt != '1) begin
        toCnt <= toCnt + 32'd1;
      end
    end
  end

  // Saturating count of bad latches
  always_ff @(posedge Clock) begin
    if (Reset) begin
      errCnt <= '0;
    end else if (badLatch && (errCnt != '1)) begin
      errCnt <= errCnt + ERRCNT_WIDTH'(1);
    end
  end

  evr_delay_line #(
    .WIDTH (TW + 2),
    .DEPTH (DLY_DEPTH)
  ) uDelay (
    .Clock (Clock),
    .Reset (Reset),
    .din   ({validReg, strobeReg, timeReg}),
    .dout  (dlyOut)
  );

  assign {TimeValid, LatchStrobe, TimeStamp} = dlyOut;
  assign ErrorCount = errCnt;
  assign BitCount   = bitCnt;

endmodule

// File: tb/tb_evr_tod_receiver.sv
// Directed self-checking bench for evr_tod_receiver in four configurations.
module tb_evr_tod_receiver;
  import evr_pkg::*;

  logic       Clock;
  logic       Reset;
  logic [7:0] evs [4];

  // A: defaults
  logic [63:0] tsA; logic tvA, lsA; logic [15:0] ecA; logic [5:0] bcA;
  // B: FRAC_MAX=4
  logic [63:0] tsB; logic tvB, lsB; logic [15:0] ecB; logic [5:0] bcB;
  // C: TIMEOUT_CYCLES=10
  logic [63:0] tsC; logic tvC, lsC; logic [15:0] ecC; logic [5:0] bcC;
  // D: SEC_WIDTH=8, DLY_DEPTH=0
  logic [39:0] tsD; logic tvD, lsD; logic [15:0] ecD; logic [5:0] bcD;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int gA     = 0;

  evr_tod_receiver uDutA (
    .Clock(Clock), .Reset(Reset), .EventStream(evs[0]),
    .TimeStamp(tsA), .TimeValid(tvA), .LatchStrobe(lsA),
    .ErrorCount(ecA), .BitCount(bcA)
  );

  evr_tod_receiver #(.FRAC_MAX(4)) uDutB (
    .Clock(Clock), .Reset(Reset), .EventStream(evs[1]),
    .TimeStamp(tsB), .TimeValid(tvB), .LatchStrobe(lsB),
    .ErrorCount(ecB), .BitCount(bcB)
  );

  evr_tod_receiver #(.TIMEOUT_CYCLES(10)) uDutC (
    .Clock(Clock), .Reset(Reset), .EventStream(evs[2]),
    .TimeStamp(tsC), .TimeValid(tvC), .LatchStrobe(lsC),
    .ErrorCount(ecC), .BitCount(bcC)
  );

  evr_tod_receiver #(.SEC_WIDTH(8), .DLY_DEPTH(0)) uDutD (
    .Clock(Clock), .Reset(Reset), .EventStream(evs[3]),
    .TimeStamp(tsD), .TimeValid(tvD), .LatchStrobe(lsD),
    .ErrorCount(ecD), .BitCount(bcD)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // One clock edge with `code` presented to instance idx; sample #1 after it
  task automatic step(input int idx, input logic [7:0] code);
    evs[idx] = code;
    @(posedge Clock);
    #1;
    evs[idx] = EVT_CODE_NONE;
    cyc++;
  endtask

  task automatic sendWord(input int idx, input logic [31:0] value, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      step(idx, value[i] ? EVT_CODE_ONE : EVT_CODE_ZERO);
    end
  endtask

  task automatic doReset();
    for (int i = 0; i < 4; i++) evs[i] = EVT_CODE_NONE;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) evs[i] = EVT_CODE_LATCH;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (tsA !== 64'h0) begin errors++; $display("FAIL reset_tsA: got %h want 0", tsA); end
    checks++; if (tvA !== 1'b0)  begin errors++; $display("FAIL reset_tvA: got %b want 0", tvA); end
    checks++; if (lsA !== 1'b0)  begin errors++; $display("FAIL reset_lsA: got %b want 0", lsA); end
    checks++; if (ecA !== 16'h0) begin errors++; $display("FAIL reset_ecA: got %h want 0", ecA); end
    checks++; if (bcA !== 6'd0)  begin errors++; $display("FAIL reset_bcA: got %0d want 0", bcA); end
    checks++; if (tsD !== 40'h0) begin errors++; $display("FAIL reset_tsD: got %h want 0", tsD); end
    checks++; if (ecD !== 16'h0) begin errors++; $display("FAIL reset_ecD: got %h want 0", ecD); end
    for (int i = 0; i < 4; i++) evs[i] = EVT_CODE_NONE;
    Reset = 1'b0;
  endtask

  task automatic test_good_latch();
    doReset();
    sendWord(0, 32'h5A5A_0001, 32);
    checks++; if (bcA !== 6'd32) begin errors++; $display("FAIL good_bitcount: got %0d want 32", bcA); end
    checks++; if (tvA !== 1'b0) begin errors++; $display("FAIL good_prevalid: got %b want 0", tvA); end
    step(0, EVT_CODE_LATCH);
    gA = cyc;
    checks++; if (bcA !== 6'd0) begin errors++; $display("FAIL good_bitclear: got %0d want 0", bcA); end
    checks++; if (ecA !== 16'h0) begin errors++; $display("FAIL good_errcnt: got %h want 0", ecA); end
    step(0, EVT_CODE_NONE);
    checks++; if (lsA !== 1'b0) begin errors++; $display("FAIL good_strobe_early: got %b want 0", lsA); end
    step(0, EVT_CODE_NONE);
    checks++; if (tsA !== 64'h5A5A_0001_0000_0000) begin errors++; $display("FAIL good_ts: got %h want 5a5a000100000000", tsA); end
    checks++; if (tvA !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", tvA); end
    checks++; if (lsA !== 1'b1) begin errors++; $display("FAIL good_strobe: got %b want 1", lsA); end
    step(0, EVT_CODE_NONE);
    checks++; if (tsA !== 64'h5A5A_0001_0000_0001) begin errors++; $display("FAIL good_ts_inc: got %h want 5a5a000100000001", tsA); end
    checks++; if (lsA !== 1'b0) begin errors++; $display("FAIL good_strobe_once: got %b want 0", lsA); end
  endtask

  task automatic test_bad_latch();
    logic [63:0] expTs;
    sendWord(0, 32'h0000_00FF, 31);
    step(0, 8'h55);
    step(0, EVT_CODE_NONE);
    checks++; if (bcA !== 6'd31) begin errors++; $display("FAIL bad_other_code: got %0d want 31", bcA); end
    step(0, EVT_CODE_LATCH);
    checks++; if (ecA !== 16'd1) begin errors++; $display("FAIL bad_errcnt1: got %0d want 1", ecA); end
    step(0, EVT_CODE_NONE);
    step(0, EVT_CODE_NONE);
    expTs = 64'h5A5A_0001_0000_0000 + 64'(cyc - gA - 2);
    checks++; if (tvA !== 1'b0) begin errors++; $display("FAIL bad_valid: got %b want 0", tvA); end
    checks++; if (tsA !== expTs) begin errors++; $display("FAIL bad_ts_count: got %h want %h", tsA, expTs); end
    checks++; if (lsA !== 1'b0) begin errors++; $display("FAIL bad_strobe: got %b want 0", lsA); end
    step(0, EVT_CODE_NONE);
    checks++; if (tsA !== expTs + 64'd1) begin errors++; $display("FAIL bad_ts_inc: got %h want %h", tsA, expTs + 64'd1); end
    for (int i = 0; i < 33; i++) step(0, EVT_CODE_ONE);
    checks++; if (bcA !== 6'd33) begin errors++; $display("FAIL bad_bit_sat: got %0d want 33", bcA); end
    step(0, EVT_CODE_ZERO);
    checks++; if (bcA !== 6'd33) begin errors++; $display("FAIL bad_bit_hold: got %0d want 33", bcA); end
    step(0, EVT_CODE_LATCH);
    checks++; if (ecA !== 16'd2) begin errors++; $display("FAIL bad_errcnt2: got %0d want 2", ecA); end
    step(0, EVT_CODE_NONE);
    step(0, EVT_CODE_NONE);
    checks++; if (tvA !== 1'b0) begin errors++; $display("FAIL bad_valid2: got %b want 0", tvA); end
  endtask

  task automatic test_rollover();
    doReset();
    sendWord(1, 32'hFFFF_FFFF, 32);
    step(1, EVT_CODE_LATCH);
    step(1, EVT_CODE_NONE);
    step(1, EVT_CODE_NONE);
    checks++; if (tsB !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL roll_t0: got %h want ffffffff00000000", tsB); end
    checks++; if (tvB !== 1'b1) begin errors++; $display("FAIL roll_valid: got %b want 1", tvB); end
    for (int k = 1; k <= 3; k++) begin
      step(1, EVT_CODE_NONE);
      checks++;
      if (tsB !== {32'hFFFF_FFFF, 32'(k)}) begin
        errors++; $display("FAIL roll_tick%0d: got %h want ffffffff%08h", k, tsB, k);
      end
    end
    step(1, EVT_CODE_NONE);
    checks++; if (tsB !== 64'h0) begin errors++; $display("FAIL roll_wrap: got %h want 0", tsB); end
  endtask

  task automatic test_timeout();
    int g;
    doReset();
    sendWord(2, 32'h0000_0003, 32);
    step(2, EVT_CODE_LATCH);
    g = cyc;
    while (cyc - g < 2) step(2, EVT_CODE_NONE);
    checks++; if (tvC !== 1'b1) begin errors++; $display("FAIL to_valid_set: got %b want 1", tvC); end
    checks++; if (lsC !== 1'b1) begin errors++; $display("FAIL to_strobe: got %b want 1", lsC); end
    while (cyc - g < 11) step(2, EVT_CODE_NONE);
    checks++; if (tvC !== 1'b1) begin errors++; $display("FAIL to_valid_before: got %b want 1", tvC); end
    step(2, EVT_CODE_NONE);
    checks++; if (tvC !== 1'b0) begin errors++; $display("FAIL to_valid_drop: got %b want 0", tvC); end
    while (cyc - g < 20) step(2, EVT_CODE_NONE);
    checks++; if (tvC !== 1'b0) begin errors++; $display("FAIL to_valid_stays: got %b want 0", tvC); end
    sendWord(2, 32'h0000_0007, 32);
    step(2, EVT_CODE_LATCH);
    step(2, EVT_CODE_NONE);
    step(2, EVT_CODE_NONE);
    checks++; if (tvC !== 1'b1) begin errors++; $display("FAIL to_valid_reload: got %b want 1", tvC); end
    checks++; if (tsC !== 64'h0000_0007_0000_0000) begin errors++; $display("FAIL to_ts_reload: got %h want 0000000700000000", tsC); end
  endtask

  task automatic test_reset_mid();
    doReset();
    sendWord(0, 32'h0000_BEEF, 16);
    checks++; if (bcA !== 6'd16) begin errors++; $display("FAIL mid_bits: got %0d want 16", bcA); end
    Reset = 1'b1;
    evs[0] = EVT_CODE_ONE;
    @(posedge Clock);
    #1;
    checks++; if (bcA !== 6'd0) begin errors++; $display("FAIL mid_rst_bits: got %0d want 0", bcA); end
    checks++; if (tsA !== 64'h0) begin errors++; $display("FAIL mid_rst_ts: got %h want 0", tsA); end
    checks++; if ({tvA, lsA} !== 2'b00) begin errors++; $display("FAIL mid_rst_flags: got %b want 00", {tvA, lsA}); end
    checks++; if (ecA !== 16'h0) begin errors++; $display("FAIL mid_rst_err: got %h want 0", ecA); end
    evs[0] = EVT_CODE_NONE;
    Reset = 1'b0;
    sendWord(0, 32'hCAFE_F00D, 32);
    step(0, EVT_CODE_LATCH);
    checks++; if (ecA !== 16'h0) begin errors++; $display("FAIL mid_errcnt: got %h want 0", ecA); end
    step(0, EVT_CODE_NONE);
    step(0, EVT_CODE_NONE);
    checks++; if (tvA !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", tvA); end
    checks++; if (tsA !== 64'hCAFE_F00D_0000_0000) begin errors++; $display("FAIL mid_ts: got %h want cafef00d00000000", tsA); end
  endtask

  task automatic test_no_delay();
    doReset();
    sendWord(3, 32'h0000_00A5, 8);
    checks++; if (bcD !== 6'd8) begin errors++; $display("FAIL nd_bits: got %0d want 8", bcD); end
    step(3, EVT_CODE_LATCH);
    checks++; if (tsD !== 40'hA5_0000_0000) begin errors++; $display("FAIL nd_ts: got %h want a500000000", tsD); end
    checks++; if (tvD !== 1'b1) begin errors++; $display("FAIL nd_valid: got %b want 1", tvD); end
    checks++; if (lsD !== 1'b1) begin errors++; $display("FAIL nd_strobe: got %b want 1", lsD); end
    step(3, EVT_CODE_NONE);
    checks++; if (tsD !== 40'hA5_0000_0001) begin errors++; $display("FAIL nd_ts_inc: got %h want a500000001", tsD); end
    checks++; if (lsD !== 1'b0) begin errors++; $display("FAIL nd_strobe_once: got %b want 0", lsD); end
  endtask

  initial begin
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) evs[i] = EVT_CODE_NONE;
    test_reset();
    test_good_latch();
    test_bad_latch();
    test_rollover();
    test_timeout();
    test_reset_mid();
    test_no_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/evr_tod_receiver.md
EVR_TOD_RECEIVER -- requirements
Module: evr_tod_receiver

Interface
REQ-001 Parameter SEC_WIDTH, default 32: number of seconds bits carried serially, MSB first; legal range 1..32.
REQ-002 Parameter FRAC_WIDTH, default 32: width of the sub-second tick counter; legal range 1..32.
REQ-003 Parameter FRAC_MAX, default 0: tick count per second; 0 means no rollover, and the full {sec,frac} word increments as one binary counter.
REQ-004 Parameter DLY_DEPTH, default 2: output pipeline stages after the time register; legal range 0..8.
REQ-005 Parameter TIMEOUT_CYCLES, default 0: cycles without a good latch before TimeValid drops; 0 disables the timeout.
REQ-006 Parameters EVT_ZERO = 8'h70, EVT_ONE = 8'h71, EVT_LATCH = 8'h7D: event codes for data bit 0, data bit 1, and latch.
REQ-007 Clock  input  1: system/event clock; every register changes on its rising edge only.
REQ-008 Reset  input  1: synchronous, active-high reset.
REQ-009 EventStream  input  8: one event code per cycle; 8'h00 means no event.
REQ-010 TimeStamp  output  SEC_WIDTH+FRAC_WIDTH: {seconds, ticks} after the delay pipeline.
REQ-011 TimeValid  output  1: the most recent latch was good and the timeout has not expired; delayed in step with TimeStamp.
REQ-012 LatchStrobe  output  1: one-cycle pulse, high in the first cycle TimeStamp shows a newly loaded good time.
REQ-013 ErrorCount  output  16: saturating count of bad latches.
REQ-014 BitCount  output  6: debug copy of the current serial bit count.

Function
REQ-015 EVT_ZERO or EVT_ONE shifts the bit into LSB of a SEC_WIDTH shift register; the first received bit ends up as the MSB.
REQ-016 BitCount increments on every data event and saturates at SEC_WIDTH+1, which marks overflow.
REQ-017 EVT_LATCH is good if BitCount equals SEC_WIDTH, and bad otherwise.
REQ-018 EVT_LATCH always clears BitCount to 0 and the shift register to 0.
REQ-019 On a good latch at edge N, the time register shall equal {shift, 0} after edge N.
REQ-020 On a good latch, the valid flag is set and the timeout counter is cleared.
REQ-021 On a bad latch, the time register is not loaded and keeps incrementing.
REQ-022 On a bad latch, ErrorCount increments and stops at 16'hFFFF.
REQ-023 On a bad latch, the valid flag clears.
REQ-024 With FRAC_MAX=0, the time register increments by 1 every cycle that is not a good latch, wrapping modulo 2^(SEC_WIDTH+FRAC_WIDTH).
REQ-025 With FRAC_MAX>0, when ticks equals FRAC_MAX-1, ticks goes to 0 and seconds increments, wrapping modulo 2^SEC_WIDTH; otherwise ticks increments.
REQ-026 A good latch takes priority over rollover and increment in the same cycle.
REQ-027 Timeout counter: increments each cycle while valid is set, and saturates.
REQ-028 Timeout expiry: when the counter reaches TIMEOUT_CYCLES-1, the valid flag clears on the next edge.
REQ-029 Timeout and valid are independent of data events.
REQ-030 TimeStamp, TimeValid and LatchStrobe equal the internal time, valid and good-latch signals delayed by exactly DLY_DEPTH cycles.
REQ-031 With DLY_DEPTH=0, the outputs are driven directly from the internal registers.
REQ-032 Codes other than the three configured events, including 8'h00, leave the shift register, BitCount, ErrorCount and valid state unchanged.

Reset
REQ-033 Reset clears all of the following to 0, with priority over every event: shift register, BitCount, time register, valid flag, timeout counter, ErrorCount, and every pipeline stage.
REQ-034 Reset asserted mid-sequence discards any partial seconds word; the next latch after release is bad unless a full SEC_WIDTH bits arrive first.
REQ-035 TimeStamp, TimeValid, LatchStrobe and ErrorCount read 0 in the first cycle after reset and until new data propagates.

Structure
REQ-036 A shared package evr_pkg holds the event code constants and the ERRCNT_WIDTH=16 constant.
REQ-037 The delay line is a sub-module evr_delay_line (parameters WIDTH, DEPTH; ports Clock, Reset, din, dout), instantiated once over {valid, strobe, time}.

Verification
REQ-038 Defaults; send 32 data events encoding 32'h5A5A_0001, then EVT_LATCH at edge N -> after edge N+2, TimeStamp=64'h5A5A_0001_0000_0000, TimeValid=1, LatchStrobe=1 for one cycle; then +1 per cycle.
REQ-039 Defaults; send 31 bits then EVT_LATCH -> ErrorCount=1, TimeValid=0, TimeStamp keeps counting and is not reloaded; a following 33-bit burst then latch -> ErrorCount=2.
REQ-040 FRAC_MAX=4; good latch with seconds 32'hFFFF_FFFF -> ticks run 0,1,2,3, then TimeStamp={32'h0, 32'h0}.
REQ-041 TIMEOUT_CYCLES=10; good latch, then idle -> TimeValid falls DLY_DEPTH+10 cycles after the internal load and stays 0 until the next good latch.
REQ-042 Assert Reset after 16 bits, release it, send 32 bits then latch -> good latch, ErrorCount=0, and all outputs were 0 during reset.
REQ-043 DLY_DEPTH=0 and SEC_WIDTH=8; send 8'hA5 then latch -> TimeStamp={8'hA5, 32'h0} in the cycle after the latch edge.
